// File: rtl/padded_row_buffer.sv
// ============================================================================
// padded_row_buffer
//   Three-slot row buffer presenting a vertical 3-row window of padded rows.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module padded_row_buffer #(
  parameter int DW = 8,
  parameter int W  = 418,
  parameter int CH = 3,
  parameter int H  = 418,
  parameter int CW = $clog2(H + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*W*DW-1:0]   in_row,
  input  logic                 out_ready,
  output logic                 win_valid,
  output logic [CH*W*DW-1:0]   row_top,
  output logic [CH*W*DW-1:0]   row_mid,
  output logic [CH*W*DW-1:0]   row_bot,
  output logic [CW-1:0]        row_count,
  output logic                 frame_done
);

  localparam int RW = CH * W * DW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  localparam logic [CW-1:0] LAST_ROW  = CW'(H - 1);
  localparam logic [CW-1:0] THIRD_ROW = CW'(2);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    wr_sel;
  logic [1:0]    sel_mid;
  logic [1:0]    sel_bot;
  logic [RW-1:0] slot [3];

  logic accept;
  logic last_accept;
  logic third_accept;

  assign accept       = in_valid & in_ready;
  assign last_accept  = accept & (row_count == LAST_ROW);
  assign third_accept = accept & (row_count == THIRD_ROW);

  // Slot indices of the middle and newest rows relative to the write pointer.
  always_comb begin
    sel_mid = 2'd1;
    sel_bot = 2'd2;
    case (wr_sel)
      2'd0:    begin sel_mid = 2'd1; sel_bot = 2'd2; end
      2'd1:    begin sel_mid = 2'd2; sel_bot = 2'd0; end
      2'd2:    begin sel_mid = 2'd0; sel_bot = 2'd1; end
      default: begin sel_mid = 2'd1; sel_bot = 2'd2; end
    endcase
  end

  assign row_top = slot[wr_sel];
  assign row_mid = slot[sel_mid];
  assign row_bot = slot[sel_bot];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (last_accept)       state_nxt = ST_FILL;
        else if (third_accept) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (last_accept) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: a held window blocks new rows so it stays stable.
  always_comb begin
    in_ready = 1'b0;
    if (en && (state != ST_IDLE) && !(win_valid && !out_ready)) begin
      in_ready = 1'b1;
    end
  end

  // Row storage. On the frame-completing row the write pointer returns to 0,
  // so the slots are rotated at the same time to keep the presented window
  // in oldest/middle/newest order under the reset pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        slot[i] <= '0;
      end
      wr_sel <= 2'd0;
    end else if (last_accept) begin
      slot[0] <= slot[sel_mid];
      slot[1] <= slot[sel_bot];
      slot[2] <= in_row;
      wr_sel  <= 2'd0;
    end else if (accept) begin
      slot[wr_sel] <= in_row;
      wr_sel       <= (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_accept;
      if (last_accept) begin
        row_count <= '0;
      end else if (accept) begin
        row_count <= row_count + CW'(1);
      end
    end
  end

  // An accept can only happen while the current window is consumed or absent,
  // so the accept alone decides whether a new window follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid <= 1'b0;
    end else if (accept) begin
      win_valid <= third_accept | (state == ST_STREAM);
    end else if (out_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
